// File: rtl/rr_mux_arbiter.sv
// Four-channel round-robin arbiter feeding a single registered output stage.
// The winning channel's word is latched together with its 2-bit select code,
// which downstream logic may use as a 4:1 mux select or as a source tag.

// Per-lane data gate: passes the lane word only when the lane holds the grant,
// so the four gated words can simply be OR-ed into one.
module rr_lane #(
  parameter int W = 5
) (
  input  logic         grant_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  assign data_o = data_i & {W{grant_i}};

endmodule

module rr_mux_arbiter #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [3:0]   in_valid_i,
  output logic [3:0]   in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   out_sel_o
);

  localparam int NUM_LANES = 4;

  // Rotating priority pick: ptr names the channel searched first, then the
  // search continues upward with wrap. Written as a table so no adder sits
  // on the request-to-ready path.
  function automatic logic [3:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [3:0] g;
    g = 4'b0000;
    unique case (p)
      2'd0: g = v[0] ? 4'b0001 : v[1] ? 4'b0010 : v[2] ? 4'b0100 : v[3] ? 4'b1000 : 4'b0000;
      2'd1: g = v[1] ? 4'b0010 : v[2] ? 4'b0100 : v[3] ? 4'b1000 : v[0] ? 4'b0001 : 4'b0000;
      2'd2: g = v[2] ? 4'b0100 : v[3] ? 4'b1000 : v[0] ? 4'b0001 : v[1] ? 4'b0010 : 4'b0000;
      2'd3: g = v[3] ? 4'b1000 : v[0] ? 4'b0001 : v[1] ? 4'b0010 : v[2] ? 4'b0100 : 4'b0000;
      default: g = 4'b0000;
    endcase
    return g;
  endfunction

  logic [1:0]   ptr_q, ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [1:0]   out_sel_q, out_sel_d;

  logic [3:0]   grant;
  logic         load;
  logic         xfer;
  logic [1:0]   gsel;
  logic [NUM_LANES-1:0][W-1:0] lane_data;
  logic [NUM_LANES-1:0][W-1:0] lane_gated;
  logic [W-1:0] win_data;

  assign lane_data[0] = a_i;
  assign lane_data[1] = b_i;
  assign lane_data[2] = c_i;
  assign lane_data[3] = d_i;

  // The output register can take a word when empty or being drained now.
  assign load  = !out_valid_q || out_ready_i;
  assign grant = rr_pick(in_valid_i, ptr_q);

  // Ready is withheld during reset so nothing is consumed that would be lost.
  assign in_ready_o = (load && !rst_i) ? grant : 4'b0000;
  assign xfer       = |in_ready_o;

  // One-hot grant to channel index.
  assign gsel = {grant[3] | grant[2], grant[3] | grant[1]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rr_lane #(.W(W)) u_lane (
      .grant_i (grant[i]),
      .data_i  (lane_data[i]),
      .data_o  (lane_gated[i])
    );
  end

  // OR-merge of the gated lane words; at most one lane is non-zero.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_LANES; i++) win_data = win_data | lane_gated[i];
  end

  // Next state: load winner on transfer, empty on idle load, else hold.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_sel_d   = gsel;
      ptr_d       = gsel + 2'd1;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a pending word is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule
